rmon_ctrl: RTL

RMON_CTRL -- requirements
Module: RMON_ctrl

---
 rtl/rmon_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rmon_ctrl.sv
// RMON statistics controller: clears a 64 x 32 counter RAM after reset, then
// arbitrates RX/TX increment requests as read-modify-write sequences.
// Optional build macro RMON_SATURATE_EN: counters saturate instead of wrapping.
module rmon_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_reg_apply_0,
    input  logic [5:0]  i_reg_addr_0,
    input  logic [15:0] i_reg_data_0,
    output logic        o_reg_next_0,
    input  logic        i_reg_apply_1,
    input  logic [5:0]  i_reg_addr_1,
    input  logic [15:0] i_reg_data_1,
    output logic        o_reg_next_1,
    output logic [5:0]  o_addra,
    output logic [31:0] o_dina,
    output logic        o_wea,
    input  logic [31:0] i_douta,
    output logic        o_init_done
);

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int INC_W  = 16;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W:0]     w_cnt_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic                r_gnt;
    logic                w_gnt_nxt;
    logic                w_grant;
    logic                r_done;
    logic                w_done_nxt;

    logic [ADDR_W-1:0]   r_addra;
    logic [ADDR_W-1:0]   w_addra_nxt;
    logic [DATA_W-1:0]   r_dina;
    logic [DATA_W-1:0]   w_dina_nxt;
    logic                r_wea;
    logic                w_wea_nxt;
    logic                r_next_0;
    logic                w_next_0_nxt;
    logic                r_next_1;
    logic                w_next_1_nxt;

    logic [ADDR_W-1:0]   r_lat_addr;
    logic [INC_W-1:0]    r_lat_data;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [INC_W-1:0]    w_sel_data;

    function automatic logic [DATA_W-1:0] acc_sum(input logic [DATA_W-1:0] base,
                                                  input logic [INC_W-1:0]  inc);
`ifdef RMON_SATURATE_EN
        logic [DATA_W:0] sum;
        sum = {1'b0, base} + {{(DATA_W-INC_W+1){1'b0}}, inc};
        if (sum[DATA_W]) begin
            return {DATA_W{1'b1}};
        end
        return sum[DATA_W-1:0];
`else
        return base + {{(DATA_W-INC_W){1'b0}}, inc};
`endif
    endfunction

    // Round-robin: on a tie the requester not granted last wins.
    always_comb begin
        w_gnt_nxt = r_gnt;
        if (i_reg_apply_0 && i_reg_apply_1) begin
            w_gnt_nxt = ~r_last;
        end else if (i_reg_apply_1) begin
            w_gnt_nxt = 1'b1;
        end else if (i_reg_apply_0) begin
            w_gnt_nxt = 1'b0;
        end
        w_sel_addr = w_gnt_nxt ? i_reg_addr_1 : i_reg_addr_0;
        w_sel_data = w_gnt_nxt ? i_reg_data_1 : i_reg_data_0;
    end

    // Outputs are registered: each branch computes what the RAM port shows
    // while the FSM sits in the state being entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_nxt   = r_last;
        w_done_nxt   = r_done;
        w_grant      = 1'b0;
        w_addra_nxt  = '0;
        w_dina_nxt   = '0;
        w_wea_nxt    = 1'b0;
        w_next_0_nxt = 1'b0;
        w_next_1_nxt = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_cnt[ADDR_W]) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_addra_nxt = r_cnt[ADDR_W-1:0];
                    w_wea_nxt   = 1'b1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (i_reg_apply_0 || i_reg_apply_1) begin
                    w_grant     = 1'b1;
                    w_last_nxt  = w_gnt_nxt;
                    w_addra_nxt = w_sel_addr;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_addra_nxt = r_lat_addr;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_addra_nxt  = r_lat_addr;
                w_dina_nxt   = acc_sum(i_douta, r_lat_data);
                w_wea_nxt    = 1'b1;
                w_next_0_nxt = ~r_gnt;
                w_next_1_nxt = r_gnt;
                w_state_nxt  = ST_WRITE;
            end
            ST_WRITE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_last   <= 1'b1;
            r_gnt    <= 1'b0;
            r_done   <= 1'b0;
            r_addra  <= '0;
            r_dina   <= '0;
            r_wea    <= 1'b0;
            r_next_0 <= 1'b0;
            r_next_1 <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last   <= w_last_nxt;
            r_done   <= w_done_nxt;
            r_addra  <= w_addra_nxt;
            r_dina   <= w_dina_nxt;
            r_wea    <= w_wea_nxt;
            r_next_0 <= w_next_0_nxt;
            r_next_1 <= w_next_1_nxt;
            if (w_grant) begin
                r_gnt <= w_gnt_nxt;
            end
        end
    end

    // Operands of the update in flight; held so requesters may change inputs.
    always_ff @(posedge i_clk) begin
        if (w_grant) begin
            r_lat_addr <= w_sel_addr;
            r_lat_data <= w_sel_data;
        end
    end

    assign o_addra      = r_addra;
    assign o_dina       = r_dina;
    assign o_wea        = r_wea;
    assign o_reg_next_0 = r_next_0;
    assign o_reg_next_1 = r_next_1;
    assign o_init_done  = r_done;

endmodule
